// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the common-data-bus arbitration signals between the functional
// units and the CDB arbiter.
//   CDB_rts         units -> arbiter : per-unit request-to-send (level)
//   CDB_xmit        arbiter -> units : one-hot grant, registered
//   CDB_grant_id    arbiter -> units : index of current grantee, 0 when idle
//   CDB_busy        arbiter -> units : high while any grant is active
//   CDB_abort       arbiter -> units : one-cycle pulse on early withdrawal
//   CDB_grant_count arbiter -> units : completed-grant counter, present only
//                                      when CDB_ARB_STATS_EN is defined
// Modports: master = arbiter side, slave = requester side.
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3
) ();

  logic [NUM_UNITS-1:0] CDB_rts;
  logic [NUM_UNITS-1:0] CDB_xmit;
  logic [ID_W-1:0]      CDB_grant_id;
  logic                 CDB_busy;
  logic                 CDB_abort;
`ifdef CDB_ARB_STATS_EN
  logic [15:0]          CDB_grant_count;

  modport master (
    input  CDB_rts,
    output CDB_xmit, CDB_grant_id, CDB_busy, CDB_abort, CDB_grant_count
  );

  modport slave (
    output CDB_rts,
    input  CDB_xmit, CDB_grant_id, CDB_busy, CDB_abort, CDB_grant_count
  );
`else
  modport master (
    input  CDB_rts,
    output CDB_xmit, CDB_grant_id, CDB_busy, CDB_abort
  );

  modport slave (
    output CDB_rts,
    input  CDB_xmit, CDB_grant_id, CDB_busy, CDB_abort
  );
`endif

endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for the common data bus. A unit raises its rts; the
// arbiter grants one unit at a time, holds the grant XMIT_CYCLES cycles,
// then inserts one dead (RECOVER) cycle so the tri-state CDB nets float and
// the grantee can drop rts on the falling xmit.
//
// Ports:
//   clock  : system clock, posedge active
//   reset  : asynchronous, active-high reset
//   bus    : cdb_arbiter_if.master (CDB_rts in; CDB_xmit, CDB_grant_id,
//            CDB_busy, CDB_abort [, CDB_grant_count] out)
//
// Optional feature: define CDB_ARB_STATS_EN to add the 16-bit saturating
// CDB_grant_count output counting completed (non-aborted) grants.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_UNITS   = 4,
  parameter int XMIT_CYCLES = 1,
  parameter int ID_W        = 3
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.master bus
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XMIT    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_UNITS-1:0] xmit_q, xmit_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 abort_q, abort_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      last_id_q, last_id_d;
  logic                 mask_vld_q, mask_vld_d;
`ifdef CDB_ARB_STATS_EN
  logic [15:0]          grant_count_q, grant_count_d;
`endif

  logic [NUM_UNITS-1:0] last_oh_s;
  logic [NUM_UNITS-1:0] req_masked_s;
  logic [ID_W:0]        pick_s;
  logic                 pick_found_s;
  logic [ID_W-1:0]      pick_idx_s;
  logic                 grantee_rts_s;
  logic                 last_rts_s;
  logic [ID_W-1:0]      ptr_after_s;

  // One-hot vector for a unit index; indices beyond NUM_UNITS-1 give zero.
  function automatic logic [NUM_UNITS-1:0] to_onehot(input logic [ID_W-1:0] idx);
    logic [NUM_UNITS-1:0] one_v;
    one_v    = '0;
    one_v[0] = 1'b1;
    return one_v << idx;
  endfunction

  // Returns {found, index} of the first set request at or above ptr,
  // wrapping to index 0; only indices below NUM_UNITS are ever examined.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_UNITS-1:0] req,
                                            input logic [ID_W-1:0]      ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      if (!found && req[j] && (ID_W'(j) >= ptr)) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_UNITS; j++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
    return {found, idx};
  endfunction

  // Request masking and round-robin selection.
  always_comb begin
    last_oh_s     = to_onehot(last_id_q);
    last_rts_s    = |(bus.CDB_rts & last_oh_s);
    // xmit_q is the grantee's one-hot, so this tests the grantee's rts.
    grantee_rts_s = |(bus.CDB_rts & xmit_q);
    if (mask_vld_q) begin
      req_masked_s = bus.CDB_rts & ~last_oh_s;
    end else begin
      req_masked_s = bus.CDB_rts;
    end
    pick_s       = rr_pick(req_masked_s, rr_ptr_q);
    pick_found_s = pick_s[ID_W];
    pick_idx_s   = pick_s[ID_W-1:0];
    if (grant_id_q == ID_W'(NUM_UNITS - 1)) begin
      ptr_after_s = '0;
    end else begin
      ptr_after_s = grant_id_q + ID_W'(1);
    end
  end

  // Next-state and output logic of the grant FSM.
  always_comb begin
    state_d    = state_q;
    xmit_d     = xmit_q;
    grant_id_d = grant_id_q;
    hold_cnt_d = hold_cnt_q;
    abort_d    = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    last_id_d  = last_id_q;
`ifdef CDB_ARB_STATS_EN
    grant_count_d = grant_count_q;
`endif
    // The stale-request mask drops as soon as the last grantee's rts is low.
    if (mask_vld_q && !last_rts_s) begin
      mask_vld_d = 1'b0;
    end else begin
      mask_vld_d = mask_vld_q;
    end

    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          xmit_d     = to_onehot(pick_idx_s);
          grant_id_d = pick_idx_s;
          hold_cnt_d = CNT_W'(XMIT_CYCLES - 1);
          mask_vld_d = 1'b0;
          state_d    = XMIT;
        end else begin
          state_d = IDLE;
        end
      end
      XMIT: begin
        if (!grantee_rts_s || (hold_cnt_q == '0)) begin
          // Both early withdrawal and normal completion end the grant.
          xmit_d     = '0;
          grant_id_d = '0;
          rr_ptr_d   = ptr_after_s;
          last_id_d  = grant_id_q;
          mask_vld_d = 1'b1;
          state_d    = RECOVER;
          if (!grantee_rts_s) begin
            abort_d = 1'b1;
          end else begin
            abort_d = 1'b0;
`ifdef CDB_ARB_STATS_EN
            if (grant_count_q != 16'hFFFF) begin
              grant_count_d = grant_count_q + 16'd1;
            end else begin
              grant_count_d = grant_count_q;
            end
`endif
          end
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        xmit_d     = '0;
        grant_id_d = '0;
      end
    endcase
  end

  // State and output registers; reset clears the grant without a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      xmit_q     <= '0;
      grant_id_q <= '0;
      hold_cnt_q <= '0;
      abort_q    <= 1'b0;
      rr_ptr_q   <= '0;
      last_id_q  <= '0;
      mask_vld_q <= 1'b0;
`ifdef CDB_ARB_STATS_EN
      grant_count_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      xmit_q     <= xmit_d;
      grant_id_q <= grant_id_d;
      hold_cnt_q <= hold_cnt_d;
      abort_q    <= abort_d;
      rr_ptr_q   <= rr_ptr_d;
      last_id_q  <= last_id_d;
      mask_vld_q <= mask_vld_d;
`ifdef CDB_ARB_STATS_EN
      grant_count_q <= grant_count_d;
`endif
    end
  end

  assign bus.CDB_xmit     = xmit_q;
  assign bus.CDB_grant_id = grant_id_q;
  assign bus.CDB_busy     = |xmit_q;
  assign bus.CDB_abort    = abort_q;
`ifdef CDB_ARB_STATS_EN
  assign bus.CDB_grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Four arbiters with different NUM_UNITS / XMIT_CYCLES run side by side.
// Each is compared every cycle against a transaction-level model: a grant
// lasts a number of cycles, ends early if the grantee withdraws, and is
// followed by one dead cycle; the next grant goes to the first eligible
// requester in rotation order after the previous grantee.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int ND = 4;

  logic       clock;
  logic       reset;
  logic [7:0] rts_v [ND];

  int cfg_n [ND] = '{4, 4, 4, 5};
  int cfg_x [ND] = '{1, 3, 4, 2};

  int checks;
  int failures;

  // transaction model state per DUT
  int m_gnt   [ND];  // current grantee, -1 when none
  int m_left  [ND];  // cycles of the grant still to run
  int m_dead  [ND];  // 1 during the dead cycle after a grant
  int m_ptr   [ND];  // unit searched first
  int m_mask  [ND];  // last grantee still ineligible
  int m_midx  [ND];
  int m_abort [ND];
  int m_cnt   [ND];

  logic [7:0]  obs_xmit  [ND];
  logic [2:0]  obs_id    [ND];
  logic        obs_busy  [ND];
  logic        obs_abort [ND];

  cdb_arbiter_if #(.NUM_UNITS(4), .ID_W(3)) if0 ();
  cdb_arbiter_if #(.NUM_UNITS(4), .ID_W(3)) if1 ();
  cdb_arbiter_if #(.NUM_UNITS(4), .ID_W(3)) if2 ();
  cdb_arbiter_if #(.NUM_UNITS(5), .ID_W(3)) if3 ();

  cdb_arbiter #(.NUM_UNITS(4), .XMIT_CYCLES(1), .ID_W(3)) dut0 (.clock(clock), .reset(reset), .bus(if0.master));
  cdb_arbiter #(.NUM_UNITS(4), .XMIT_CYCLES(3), .ID_W(3)) dut1 (.clock(clock), .reset(reset), .bus(if1.master));
  cdb_arbiter #(.NUM_UNITS(4), .XMIT_CYCLES(4), .ID_W(3)) dut2 (.clock(clock), .reset(reset), .bus(if2.master));
  cdb_arbiter #(.NUM_UNITS(5), .XMIT_CYCLES(2), .ID_W(3)) dut3 (.clock(clock), .reset(reset), .bus(if3.master));

  assign if0.CDB_rts = rts_v[0][3:0];
  assign if1.CDB_rts = rts_v[1][3:0];
  assign if2.CDB_rts = rts_v[2][3:0];
  assign if3.CDB_rts = rts_v[3][4:0];

  assign obs_xmit[0] = {4'd0, if0.CDB_xmit};
  assign obs_xmit[1] = {4'd0, if1.CDB_xmit};
  assign obs_xmit[2] = {4'd0, if2.CDB_xmit};
  assign obs_xmit[3] = {3'd0, if3.CDB_xmit};
  assign obs_id[0] = if0.CDB_grant_id;
  assign obs_id[1] = if1.CDB_grant_id;
  assign obs_id[2] = if2.CDB_grant_id;
  assign obs_id[3] = if3.CDB_grant_id;
  assign obs_busy[0] = if0.CDB_busy;
  assign obs_busy[1] = if1.CDB_busy;
  assign obs_busy[2] = if2.CDB_busy;
  assign obs_busy[3] = if3.CDB_busy;
  assign obs_abort[0] = if0.CDB_abort;
  assign obs_abort[1] = if1.CDB_abort;
  assign obs_abort[2] = if2.CDB_abort;
  assign obs_abort[3] = if3.CDB_abort;

`ifdef CDB_ARB_STATS_EN
  logic [15:0] obs_cnt [ND];
  assign obs_cnt[0] = if0.CDB_grant_count;
  assign obs_cnt[1] = if1.CDB_grant_count;
  assign obs_cnt[2] = if2.CDB_grant_count;
  assign obs_cnt[3] = if3.CDB_grant_count;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic bit_at(input logic [7:0] v, input int i);
    logic [2:0] k;
    k = i[2:0];
    return v[k];
  endfunction

  task automatic expect_eq(input string tag, input int d,
                           input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_gnt[d] = -1; m_left[d] = 0; m_dead[d] = 0; m_ptr[d] = 0;
    m_mask[d] = 0; m_midx[d] = 0; m_abort[d] = 0; m_cnt[d] = 0;
  endtask

  // One clock edge of the model, using the rts the DUT sampled.
  task automatic model_step(input int d);
    logic [7:0] r;
    int n;
    int u;
    r = rts_v[d];
    n = cfg_n[d];
    m_abort[d] = 0;
    if (m_mask[d] != 0 && !bit_at(r, m_midx[d])) m_mask[d] = 0;
    if (m_gnt[d] >= 0) begin
      if (!bit_at(r, m_gnt[d]) || m_left[d] == 1) begin
        if (!bit_at(r, m_gnt[d])) m_abort[d] = 1;
        else if (m_cnt[d] < 65535) m_cnt[d]++;
        m_ptr[d]  = (m_gnt[d] + 1) % n;
        m_mask[d] = 1;
        m_midx[d] = m_gnt[d];
        m_gnt[d]  = -1;
        m_dead[d] = 1;
      end else begin
        m_left[d]--;
      end
    end else if (m_dead[d] != 0) begin
      m_dead[d] = 0;
    end else begin
      for (int off = 0; off < n; off++) begin
        u = (m_ptr[d] + off) % n;
        if (m_gnt[d] < 0 && bit_at(r, u) && !(m_mask[d] != 0 && m_midx[d] == u)) begin
          m_gnt[d]  = u;
          m_left[d] = cfg_x[d];
          m_mask[d] = 0;
        end
      end
    end
  endtask

  task automatic check(input int d);
    logic [7:0] ex;
    logic [2:0] eid;
    ex  = (m_gnt[d] >= 0) ? (8'd1 << m_gnt[d]) : 8'd0;
    eid = (m_gnt[d] >= 0) ? 3'(m_gnt[d]) : 3'd0;
    expect_eq("xmit",     d, {8'd0, obs_xmit[d]}, {8'd0, ex});
    expect_eq("grant_id", d, {13'd0, obs_id[d]}, {13'd0, eid});
    expect_eq("busy",     d, {15'd0, obs_busy[d]}, {15'd0, (ex != 8'd0)});
    expect_eq("abort",    d, {15'd0, obs_abort[d]}, 16'(m_abort[d]));
    expect_eq("onehot",   d, {15'd0, ($countones(obs_xmit[d]) <= 1)}, 16'd1);
`ifdef CDB_ARB_STATS_EN
    expect_eq("grant_count", d, obs_cnt[d], 16'(m_cnt[d]));
`endif
  endtask

  task automatic cycle();
    @(posedge clock);
    for (int d = 0; d < ND; d++) begin
      if (reset) model_reset(d);
      else model_step(d);
    end
    #1;
    for (int d = 0; d < ND; d++) check(d);
  endtask

  // Requesters drop rts once their grant is over, except units in keep.
  task automatic auto_drop(input logic [7:0] keep);
    for (int d = 0; d < ND; d++)
      for (int u = 0; u < cfg_n[d]; u++)
        if (m_mask[d] != 0 && m_midx[d] == u && m_gnt[d] != u && !bit_at(keep, u))
          rts_v[d][u] = 1'b0;
  endtask

  task automatic run_auto(input int k, input logic [7:0] keep);
    for (int i = 0; i < k; i++) begin
      cycle();
      auto_drop(keep);
    end
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int d = 0; d < ND; d++) rts_v[d] = v & ((8'd1 << cfg_n[d]) - 8'd1);
  endtask

  task automatic rand_update();
    for (int d = 0; d < ND; d++)
      for (int u = 0; u < cfg_n[d]; u++) begin
        if (m_gnt[d] == u) begin
          if ($urandom_range(15, 0) == 0) rts_v[d][u] = 1'b0;
        end else if (m_mask[d] != 0 && m_midx[d] == u) begin
          if ($urandom_range(3, 0) != 0) rts_v[d][u] = 1'b0;
        end else if (!rts_v[d][u]) begin
          if ($urandom_range(2, 0) == 0) rts_v[d][u] = 1'b1;
        end
      end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    set_all(8'h00);
    for (int d = 0; d < ND; d++) model_reset(d);

    // reset state, checked between edges
    #12;
    for (int d = 0; d < ND; d++) check(d);
    reset = 1'b0;
    run_auto(2, 8'h00);

    // single request to unit 2
    set_all(8'b0000_0100);
    cycle();
    expect_eq("single_xmit", 0, {8'd0, obs_xmit[0]}, 16'h0004);
    expect_eq("single_id",   0, {13'd0, obs_id[0]}, 16'd2);
    auto_drop(8'h00);
    cycle();
    expect_eq("single_fall", 0, {8'd0, obs_xmit[0]}, 16'h0000);
    auto_drop(8'h00);
    run_auto(8, 8'h00);

    // every unit requesting at once: rotation
    set_all(8'hFF);
    run_auto(30, 8'h00);

    // early withdrawal on the XMIT_CYCLES=4 instance
    set_all(8'h00);
    run_auto(8, 8'h00);
    rts_v[2] = 8'b0000_0010;
    cycle();
    expect_eq("abort_grant", 2, {8'd0, obs_xmit[2]}, 16'h0002);
    cycle();
    rts_v[2][1] = 1'b0;
    cycle();
    expect_eq("abort_pulse", 2, {15'd0, obs_abort[2]}, 16'd1);
    expect_eq("abort_fall",  2, {8'd0, obs_xmit[2]}, 16'h0000);
    cycle();
    expect_eq("abort_end",   2, {15'd0, obs_abort[2]}, 16'd0);
    run_auto(4, 8'h00);

    // stale rts from unit 0 while unit 2 waits
    set_all(8'h00);
    run_auto(8, 8'h00);
    set_all(8'b0000_0001);
    cycle();
    expect_eq("stale_first", 0, {8'd0, obs_xmit[0]}, 16'h0001);
    set_all(8'b0000_0101);
    cycle();
    auto_drop(8'h01);
    cycle();
    auto_drop(8'h01);
    cycle();
    expect_eq("stale_next", 0, {8'd0, obs_xmit[0]}, 16'h0004);
    auto_drop(8'h01);
    run_auto(12, 8'h01);

    // asynchronous reset in the middle of a grant to unit 3
    set_all(8'h00);
    run_auto(8, 8'h00);
    set_all(8'b0000_1000);
    cycle();
    expect_eq("rst_pre_xmit", 0, {8'd0, obs_xmit[0]}, 16'h0008);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      expect_eq("rst_async_xmit", d, {8'd0, obs_xmit[d]}, 16'h0000);
      expect_eq("rst_async_id",   d, {13'd0, obs_id[d]}, 16'd0);
      model_reset(d);
    end
    cycle();
    reset = 1'b0;
    cycle();
    expect_eq("rst_regrant_xmit", 0, {8'd0, obs_xmit[0]}, 16'h0008);
    expect_eq("rst_regrant_id",   0, {13'd0, obs_id[0]}, 16'd3);
    run_auto(8, 8'h00);

    // randomized traffic
    set_all(8'h00);
    for (int i = 0; i < 600; i++) begin
      cycle();
      rand_update();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) among NUM_UNITS functional units (adder RS group, multiplier RS group, load buffers, ...).
- Each unit raises CDB_rts when its result is ready. The arbiter returns a one-hot CDB_xmit grant, holds it for XMIT_CYCLES cycles, then drops it. The falling edge of xmit is what frees the unit's reservation station.
- Round-robin fairness: only one driver on the shared CDB_data/CDB_source/CDB_write tri-state nets at any time.

Parameters:
- NUM_UNITS, 4: number of requesting functional units (2..8).
- XMIT_CYCLES, 1: clock cycles each grant is held (1..15).
- ID_W, 3: width of CDB_grant_id; must satisfy 2**ID_W >= NUM_UNITS.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- CDB_rts  input  NUM_UNITS  per-unit request-to-send; level, held until xmit falls.
- CDB_xmit  output  NUM_UNITS  one-hot (or zero) grant; registered.
- CDB_grant_id  output  ID_W  index of current grantee; 0 when idle.
- CDB_busy  output  1  high while any CDB_xmit bit is high.
- CDB_abort  output  1  one-cycle pulse when a grantee drops rts before its hold completes.

Behaviour:
- Reset (async, while high):
  - CDB_xmit=0, CDB_grant_id=0, CDB_busy=0, CDB_abort=0.
  - state=IDLE, rr_ptr=0, hold counter=0.
  - A reset asserted mid-XMIT removes the grant immediately, without waiting for a clock.
- States: IDLE, XMIT, RECOVER (2-bit register).
- IDLE:
  - If any masked request is present, pick the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_UNITS-1, 0, ...).
  - At that posedge: CDB_xmit<=onehot(k), CDB_grant_id<=k, hold counter<=XMIT_CYCLES-1, state<=XMIT.
  - No request: all outputs stay 0.
- Latency: rts sampled high at posedge N means xmit is high from posedge N until posedge N+XMIT_CYCLES.
- XMIT, at each posedge:
  - If CDB_rts[k]==0 (early withdrawal): CDB_xmit<=0, CDB_abort<=1 for one cycle, state<=RECOVER.
  - Else if counter==0: CDB_xmit<=0, state<=RECOVER.
  - Else: counter decrements.
  - In both exit cases, rr_ptr<=(k+1) mod NUM_UNITS.
- RECOVER:
  - Exactly one dead cycle with no grant, so units can deassert rts on the falling xmit and the CDB nets float.
  - Request k (the last grantee) is masked during this cycle.
  - Next state is IDLE.
- Masking: an rts from the last grantee remains masked in the following IDLE cycle if still high. The mask clears once that rts is observed low or another unit is granted.
- Simultaneous requests: resolved strictly by rts position relative to rr_ptr; there is no fixed priority.
- Back-to-back throughput: one grant per XMIT_CYCLES+2 cycles.
- Requests arriving during XMIT/RECOVER are held by the requester and considered in the next IDLE.
- Invariant: popcount(CDB_xmit)<=1 at all times. CDB_busy is derived combinationally as |CDB_xmit.
- NUM_UNITS not a power of two: the search wraps at NUM_UNITS-1, and indices >= NUM_UNITS are never granted.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- When defined, adds output CDB_grant_count (16 bits):
  - Increments on every completed (non-aborted) grant.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Single request: NUM_UNITS=4, XMIT_CYCLES=1, rts=4'b0100 at cycle 2 -> xmit=4'b0100 and grant_id=2 for exactly cycle 3; RECOVER at cycle 4; rr_ptr=3.
- Round-robin: rts=4'b1111 held, each unit dropping its rts the cycle after its xmit falls -> grant order 0,1,2,3,0. Grants are 3 cycles apart, and xmit is never multi-hot.
- Hold length: XMIT_CYCLES=3, rts=4'b0001 -> xmit[0] high for exactly 3 posedge intervals, CDB_busy matches, CDB_abort stays 0.
- Abort: XMIT_CYCLES=4, unit 1 granted, rts[1] dropped after 1 cycle -> xmit falls at the next posedge, CDB_abort pulses for 1 cycle, rr_ptr=2, grant_count unchanged (STATS_EN).
- Reset mid-transfer: assert reset between clock edges while xmit=4'b1000 -> xmit=0 and grant_id=0 immediately. After release with rts=4'b1000, unit 3 is granted again on the first posedge from IDLE.
- Stale rts: unit 0 keeps rts high through RECOVER and IDLE while rts[2]=1 -> unit 2 is granted next, never unit 0 twice in a row.
